// File: rtl/trace_player.sv
// trace_player: replays a programmed trace of WIDTH-bit vectors onto io_out; TRACE_PLAYER_LOOP_EN adds looping
module trace_player #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 8,
  parameter logic [WIDTH-1:0] IDLE_VAL = '0,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW:0]      len,
  input  logic             start,
  input  logic             stop,
`ifdef TRACE_PLAYER_LOOP_EN
  input  logic             loop,
`endif
  output logic [WIDTH-1:0] io_out,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    state_idx,
  output logic [31:0]      cycle
);
  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;
  localparam logic [AW:0] max_len = (AW+1)'(DEPTH);
  state_t state, nstate;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] eff_len, start_len;
  logic [AW-1:0] nidx;
  logic [WIDTH-1:0] nio;
  logic [31:0] ncycle;
  logic last, loop_en;
`ifdef TRACE_PLAYER_LOOP_EN
  assign loop_en = loop;
`else
  assign loop_en = 1'b0;
`endif
  assign start_len = (len > max_len) ? max_len : len;
  assign last = {1'b0, state_idx} == eff_len - (AW+1)'(1);
  always_ff @(posedge clock)
    if (wr_en && state != PLAY) mem[wr_addr] <= wr_data;
  always_comb begin
    nstate = state;
    if (state == IDLE && start && !stop) nstate = (start_len == '0) ? DONE : PLAY;
    else if (state == PLAY) nstate = stop ? IDLE : (last && !loop_en) ? DONE : PLAY;
    else if (state == DONE) nstate = IDLE;
  end
  always_comb begin
    nidx = (state == PLAY && nstate == PLAY && !last) ? state_idx + AW'(1) : '0;
    nio = (nstate == PLAY) ? mem[nidx] : IDLE_VAL;
    ncycle = (state == IDLE && nstate != IDLE) ? '0 :
             (state == PLAY && cycle != '1) ? cycle + 32'd1 : cycle;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      state_idx <= '0;
      io_out <= IDLE_VAL;
      busy <= 1'b0;
      done <= 1'b0;
      cycle <= '0;
      eff_len <= '0;
    end else begin
      state <= nstate;
      state_idx <= nidx;
      io_out <= nio;
      busy <= nstate == PLAY;
      done <= nstate == DONE;
      cycle <= ncycle;
      if (state == IDLE) eff_len <= start_len;
    end
  end
endmodule
